// File: rtl/rv_pkg.sv
// ============================================================================
// Module  : rv_pkg
// Purpose : Shared integer-core constants and types used by decode, the ALU
//           and the register file.
// Contents: XLEN, NREGS and the derived register address width AW, plus the
//           reg_addr_t / xlen_t typedefs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

endpackage : rv_pkg

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module  : reg_scoreboard
// Purpose : Per-register busy tracking for destinations owned by long-latency
//           units. Handles no data, only addresses and control.
// Ports   : clk, rst            - clock, async active-high reset
//           rs1_addr, rs2_addr  - read port addresses being queried
//           we, wr_addr,wb_long - writeback; a long writeback clears busy
//           sb_set, sb_addr     - issue of a long op; reserves sb_addr
//           rs1_busy, rs2_busy  - busy state of the queried registers
//           busy_any            - OR of all busy bits
//           waw_err             - sticky: plain write hit a busy register
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
  parameter int NREGS  = rv_pkg::NREGS,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic          wb_long,
  input  logic          sb_set,
  input  logic [AW-1:0] sb_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          busy_any,
  output logic          waw_err
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             waw_q;
  logic             waw_d;
  logic             clr_fwd1;
  logic             clr_fwd2;

  // Clear is applied before set so that a same-cycle reservation of a
  // register whose previous long op is completing leaves it busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (we && wb_long && (wr_addr == AW'(i))) busy_d[i] = 1'b0;
      if (sb_set && (sb_addr == AW'(i)))        busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // busy_q[0] is never set, so a write to x0 can never raise the error.
  assign waw_d = waw_q | (we & ~wb_long & busy_q[wr_addr]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      waw_q  <= waw_d;
    end
  end

  // With forwarding, the completing long write delivers its data in the same
  // cycle, so the reader need not stall on the old busy bit.
  generate
    if (BYPASS != 0) begin : g_clr_fwd
      assign clr_fwd1 = we & wb_long & (wr_addr == rs1_addr);
      assign clr_fwd2 = we & wb_long & (wr_addr == rs2_addr);
    end else begin : g_no_clr_fwd
      assign clr_fwd1 = 1'b0;
      assign clr_fwd2 = 1'b0;
    end
  endgenerate

  assign rs1_busy = busy_q[rs1_addr] & ~clr_fwd1;
  assign rs2_busy = busy_q[rs2_addr] & ~clr_fwd2;
  assign busy_any = |busy_q;
  assign waw_err  = waw_q;

endmodule : reg_scoreboard

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module  : regfile_sb
// Purpose : Integer register file with hard-wired x0, two combinational read
//           ports with optional same-cycle write bypass, one write port, a
//           debug read port and a long-latency scoreboard.
// Ports   : clk, rst                 - clock, async active-high reset
//           rs1_addr/rs1_val         - read port 1
//           rs2_addr/rs2_val         - read port 2
//           rs1_busy/rs2_busy        - read operand has a pending long write
//           we, wr_addr, wd, wb_long - write port; wb_long marks completion
//           sb_set, sb_addr          - reserve a long-op destination
//           dbg_addr/dbg_val         - debug read (never bypassed)
//           busy_any, waw_err        - scoreboard status
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int NREGS  = rv_pkg::NREGS,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wd,
  input  logic            wb_long,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_val,
  output logic            busy_any,
  output logic            waw_err
);

  // Flattened view of storage; entry 0 is a constant zero.
  logic [NREGS-1:0][XLEN-1:0] regs_w;
  logic                       byp1;
  logic                       byp2;

  generate
    for (genvar g = 0; g < NREGS; g++) begin : g_regs
      if (g == 0) begin : g_zero
        assign regs_w[g] = '0;
      end else begin : g_store
        logic [XLEN-1:0] data_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            data_q <= '0;
          end else if (we && (wr_addr == AW'(g))) begin
            data_q <= wd;
          end
        end
        assign regs_w[g] = data_q;
      end
    end
  endgenerate

  // Forwarding is suppressed for x0 and while reset is held, so reads
  // return zero throughout reset regardless of the write port.
  generate
    if (BYPASS != 0) begin : g_bypass
      assign byp1 = we & ~rst & (wr_addr == rs1_addr) & (wr_addr != '0);
      assign byp2 = we & ~rst & (wr_addr == rs2_addr) & (wr_addr != '0);
    end else begin : g_no_bypass
      assign byp1 = 1'b0;
      assign byp2 = 1'b0;
    end
  endgenerate

  assign rs1_val = byp1 ? wd : regs_w[rs1_addr];
  assign rs2_val = byp2 ? wd : regs_w[rs2_addr];
  assign dbg_val = regs_w[dbg_addr];

  reg_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .we       (we),
    .wr_addr  (wr_addr),
    .wb_long  (wb_long),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .busy_any (busy_any),
    .waw_err  (waw_err)
  );

endmodule : regfile_sb

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module  : tb_regfile_sb
// Purpose : Self-checking bench for regfile_sb. Two instances (with and
//           without bypass) share the same stimulus; an array model of the
//           architectural state predicts every output on each falling edge,
//           and directed literal expectations pin the model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, sb_addr, dbg_addr;
  logic        we, wb_long, sb_set;
  logic [31:0] wd;

  logic [31:0] b_rs1_val, b_rs2_val, b_dbg_val;
  logic        b_rs1_busy, b_rs2_busy, b_busy_any, b_waw_err;
  logic [31:0] n_rs1_val, n_rs2_val, n_dbg_val;
  logic        n_rs1_busy, n_rs2_busy, n_busy_any, n_waw_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(b_rs1_val), .rs2_val(b_rs2_val),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .we(we), .wr_addr(wr_addr), .wd(wd), .wb_long(wb_long),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .dbg_addr(dbg_addr), .dbg_val(b_dbg_val),
    .busy_any(b_busy_any), .waw_err(b_waw_err)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(n_rs1_val), .rs2_val(n_rs2_val),
    .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
    .we(we), .wr_addr(wr_addr), .wd(wd), .wb_long(wb_long),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .dbg_addr(dbg_addr), .dbg_val(n_dbg_val),
    .busy_any(n_busy_any), .waw_err(n_waw_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- architectural model ----------------
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_waw;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_waw = 1'b0;
    end else begin
      if (we && wr_addr != 0) begin
        if (!wb_long && m_busy[wr_addr]) m_waw = 1'b1;
        m_regs[wr_addr] = wd;
      end
      if (we && wb_long) m_busy[wr_addr] = 1'b0;
      // A new reservation in the same cycle overrides the completion.
      if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && !rst && we && wr_addr == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (byp && we && wb_long && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_any();
    logic r = 1'b0;
    for (int i = 0; i < 32; i++) r |= m_busy[i];
    return r;
  endfunction

  always @(negedge clk) begin
    chk("byp rs1_val",  b_rs1_val,  exp_rd(rs1_addr, 1'b1));
    chk("byp rs2_val",  b_rs2_val,  exp_rd(rs2_addr, 1'b1));
    chk("byp rs1_busy", 32'(b_rs1_busy), 32'(exp_busy(rs1_addr, 1'b1)));
    chk("byp rs2_busy", 32'(b_rs2_busy), 32'(exp_busy(rs2_addr, 1'b1)));
    chk("byp dbg_val",  b_dbg_val,  exp_rd(dbg_addr, 1'b0));
    chk("byp busy_any", 32'(b_busy_any), 32'(exp_any()));
    chk("byp waw_err",  32'(b_waw_err),  32'(m_waw));
    chk("nob rs1_val",  n_rs1_val,  exp_rd(rs1_addr, 1'b0));
    chk("nob rs2_val",  n_rs2_val,  exp_rd(rs2_addr, 1'b0));
    chk("nob rs1_busy", 32'(n_rs1_busy), 32'(exp_busy(rs1_addr, 1'b0)));
    chk("nob rs2_busy", 32'(n_rs2_busy), 32'(exp_busy(rs2_addr, 1'b0)));
    chk("nob dbg_val",  n_dbg_val,  exp_rd(dbg_addr, 1'b0));
    chk("nob busy_any", 32'(n_busy_any), 32'(exp_any()));
    chk("nob waw_err",  32'(n_waw_err),  32'(m_waw));
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    we = 0; wb_long = 0; sb_set = 0;
    wr_addr = 0; sb_addr = 0; wd = 0;
    rs1_addr = 0; rs2_addr = 0; dbg_addr = 0;
  endtask

  // Advance to just after the next rising edge and clear the controls.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    we = 0; wb_long = 0; sb_set = 0; wd = 0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset rs1_val",  b_rs1_val, 32'h0);
    chk("reset busy_any", 32'(b_busy_any), 32'h0);
    chk("reset waw_err",  32'(n_waw_err),  32'h0);

    // x5 write, then asynchronous reset mid-cycle wipes it
    next_cycle(); we = 1; wr_addr = 5; wd = 32'hDEADBEEF; rs1_addr = 5;
    #1;
    chk("x5 byp same-cycle", b_rs1_val, 32'hDEADBEEF);
    chk("x5 nob same-cycle", n_rs1_val, 32'h0);
    next_cycle(); rs1_addr = 5; dbg_addr = 5;
    #1;
    chk("x5 stored rs1", n_rs1_val, 32'hDEADBEEF);
    chk("x5 stored dbg", b_dbg_val, 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    chk("mid-cycle reset rs1", b_rs1_val, 32'h0);
    chk("mid-cycle reset dbg", n_dbg_val, 32'h0);
    next_cycle(); rst = 1'b0;

    // x0 writes and reservations are discarded
    we = 1; wr_addr = 0; wd = 32'hFFFFFFFF; sb_set = 1; sb_addr = 0; rs1_addr = 0;
    #1;
    chk("x0 same-cycle byp", b_rs1_val, 32'h0);
    next_cycle(); rs1_addr = 0;
    #1;
    chk("x0 rs1_val",  b_rs1_val, 32'h0);
    chk("x0 busy_any", 32'(b_busy_any), 32'h0);

    // bypass on x7; debug port is never bypassed
    next_cycle(); we = 1; wr_addr = 7; wd = 32'h1234; rs1_addr = 7; dbg_addr = 7;
    #1;
    chk("x7 byp rs1", b_rs1_val, 32'h1234);
    chk("x7 nob rs1", n_rs1_val, 32'h0);
    chk("x7 dbg",     b_dbg_val, 32'h0);
    next_cycle(); rs1_addr = 7;
    #1;
    chk("x7 nob next", n_rs1_val, 32'h1234);

    // scoreboard on x10
    next_cycle(); sb_set = 1; sb_addr = 10; rs2_addr = 10;
    #1;
    chk("x10 busy before edge", 32'(b_rs2_busy), 32'h0);
    next_cycle(); rs2_addr = 10;
    #1;
    chk("x10 busy",     32'(n_rs2_busy), 32'h1);
    chk("x10 busy_any", 32'(b_busy_any), 32'h1);
    next_cycle(); we = 1; wb_long = 1; wr_addr = 10; wd = 42; rs2_addr = 10;
    #1;
    chk("x10 byp clear busy", 32'(b_rs2_busy), 32'h0);
    chk("x10 byp val",        b_rs2_val, 32'd42);
    chk("x10 nob busy held",  32'(n_rs2_busy), 32'h1);
    next_cycle(); rs2_addr = 10;
    #1;
    chk("x10 nob val",   n_rs2_val, 32'd42);
    chk("x10 busy_any0", 32'(n_busy_any), 32'h0);

    // same-cycle set and clear on x3: set wins
    next_cycle(); sb_set = 1; sb_addr = 3;
    next_cycle(); sb_set = 1; sb_addr = 3; we = 1; wb_long = 1; wr_addr = 3; wd = 5; rs1_addr = 3;
    #1;
    chk("x3 byp val", b_rs1_val, 32'd5);
    next_cycle(); rs1_addr = 3;
    #1;
    chk("x3 still busy", 32'(b_rs1_busy), 32'h1);
    chk("x3 val",        n_rs1_val, 32'd5);
    chk("x3 no waw",     32'(b_waw_err), 32'h0);

    // long writeback to a non-busy register is not an error
    next_cycle(); we = 1; wb_long = 1; wr_addr = 9; wd = 77;
    next_cycle(); rs1_addr = 9;
    #1;
    chk("x9 val",    n_rs1_val, 32'd77);
    chk("x9 no waw", 32'(n_waw_err), 32'h0);

    // WAW on busy x4
    next_cycle(); sb_set = 1; sb_addr = 4;
    next_cycle(); we = 1; wr_addr = 4; wd = 99; rs2_addr = 4;
    #1;
    chk("x4 waw not yet", 32'(b_waw_err), 32'h0);
    next_cycle(); rs2_addr = 4;
    #1;
    chk("x4 val",  b_rs2_val, 32'd99);
    chk("x4 busy", 32'(n_rs2_busy), 32'h1);
    chk("x4 waw",  32'(n_waw_err), 32'h1);
    repeat (3) next_cycle();
    #1;
    chk("waw sticky", 32'(b_waw_err), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("reset clears waw",  32'(b_waw_err), 32'h0);
    chk("reset clears busy", 32'(n_busy_any), 32'h0);
    next_cycle(); rst = 1'b0;
    repeat (2) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_regfile_sb

`default_nettype wire
